// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared defaults, skid-state enum and step-check helper for the Gray decode pipeline
package gray_pkg;

  localparam int GRAY_WIDTH = 4;
  localparam int GRAY_ERR_W = 8;
  localparam int GRAY_MAX_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  // True when exactly one bit of diff is set (a legal Gray step)
  function automatic logic single_bit(input logic [GRAY_MAX_W-1:0] diff);
    return (diff != '0) && ((diff & (diff - 16'd1)) == '0);
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// rtl/gray_to_bin.sv - combinational Gray-to-binary decode
module gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at and above it
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_decoder_pipe.sv
// rtl/gray_decoder_pipe.sv - Gray decoder with step checking behind a 2-entry skid buffer
module gray_decoder_pipe
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH,
  parameter int ERR_W = GRAY_ERR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bin,
  output logic             out_step_err,
  output logic [ERR_W-1:0] err_count,
  input  logic             clr_err
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  skid_state_t           state;
  skid_state_t           state_nxt;
  logic [WIDTH-1:0]      dec_bin;
  logic [WIDTH-1:0]      skid_bin;
  logic                  skid_err;
  logic [WIDTH-1:0]      prev_gray;
  logic                  prev_valid;
  logic [GRAY_MAX_W-1:0] gray_diff;
  logic                  step_err;
  logic                  accept;
  logic                  xfer;

  gray_to_bin #(.WIDTH(WIDTH)) u_dec (
    .gray (in_gray),
    .bin  (dec_bin)
  );

  assign accept    = in_valid & in_ready;
  assign out_valid = (state != EMPTY);
  assign xfer      = out_valid & out_ready;
  assign gray_diff = GRAY_MAX_W'(in_gray ^ prev_gray);
  // The first word after reset has no predecessor and is never flagged
  assign step_err  = prev_valid & ~single_bit(gray_diff);

  // Skid occupancy next-state
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept) state_nxt = ONE;
      ONE: begin
        if (accept && !xfer)      state_nxt = TWO;
        else if (!accept && xfer) state_nxt = EMPTY;
      end
      TWO:     if (xfer) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // State register; in_ready is registered from the next state so out_ready never reaches it combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != TWO);
    end
  end

  // Output and skid registers: direct load when the output slot frees, otherwise park in skid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_bin      <= '0;
      out_step_err <= 1'b0;
      skid_bin     <= '0;
      skid_err     <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_bin      <= dec_bin;
            out_step_err <= step_err;
          end
        end
        ONE: begin
          if (accept && xfer) begin
            out_bin      <= dec_bin;
            out_step_err <= step_err;
          end else if (accept) begin
            skid_bin <= dec_bin;
            skid_err <= step_err;
          end
        end
        TWO: begin
          if (xfer) begin
            out_bin      <= skid_bin;
            out_step_err <= skid_err;
          end
        end
        default: ;
      endcase
    end
  end

  // Remember the last accepted Gray word for the step check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray  <= '0;
      prev_valid <= 1'b0;
    end else if (accept) begin
      prev_gray  <= in_gray;
      prev_valid <= 1'b1;
    end
  end

  // Saturating violation counter; a failing accept wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (accept && step_err) begin
      if (clr_err)                err_count <= ERR_ONE;
      else if (err_count != ERR_MAX) err_count <= err_count + ERR_ONE;
    end else if (clr_err) begin
      err_count <= '0;
    end
  end

endmodule

// File: doc/gray_decoder_pipe.md
GRAY_DECODER_PIPE -- requirements
Module: gray_decoder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the Gray/binary word width (legal range 2..16).
REQ-002 SHALL have parameter ERR_W, default 8, giving the error-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  upstream word present.
REQ-006 SHALL have port in_ready  output  1  block can accept a word.
REQ-007 SHALL have port in_gray  input  WIDTH  Gray-coded word from the upstream encoder.
REQ-008 SHALL have port out_valid  output  1  decoded word present.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-010 SHALL have port out_bin  output  WIDTH  binary value decoded from in_gray.
REQ-011 SHALL have port out_step_err  output  1  the presented word violated the single-bit-step rule.
REQ-012 SHALL have port err_count  output  ERR_W  saturating count of step violations.
REQ-013 SHALL have port clr_err  input  1  synchronous clear of err_count.

Function
REQ-014 SHALL transfer an input word when in_valid and in_ready are both 1 on a clock edge, and an output word when out_valid and out_ready are both 1.
REQ-015 SHALL decode each word as bin[WIDTH-1]=gray[WIDTH-1] and bin[i]=bin[i+1] XOR gray[i] for i below WIDTH-1.
REQ-016 SHALL register the decoded word so that out_valid rises on the edge that accepts a word into an empty block (latency 1 cycle).
REQ-017 SHALL hold a 2-entry skid buffer with three states: EMPTY (out_valid=0), ONE (output register valid), TWO (output register and skid register valid).
REQ-018 SHALL drive in_ready = 1 in EMPTY and ONE and 0 in TWO; in_ready SHALL be a registered signal with no combinational path from out_ready.
REQ-019 SHALL make these state transitions: EMPTY->ONE on input accept; ONE->TWO on accept without output transfer; ONE->EMPTY on output transfer without accept; ONE->ONE on simultaneous accept and transfer, with the new word loaded directly into the output register; TWO->ONE on output transfer, with the skid word moved into the output register.
REQ-020 SHALL keep out_bin and out_step_err stable while out_valid=1 and out_ready=0.
REQ-021 SHALL compute the step check against the previously accepted Gray word: out_step_err=1 when the Hamming distance is not exactly 1, so a repeated word (distance 0) is an error.
REQ-022 SHALL treat the wrap from max to 0 (e.g. 1000->0000 for WIDTH=4) as a legal single-bit step.
REQ-023 SHALL clear out_step_err for the first word accepted after reset, since that word has no predecessor.
REQ-024 SHALL increment err_count on each accepted word whose step check fails, saturating at 2^ERR_W-1.
REQ-025 SHALL give priority to the increment when clr_err and a failing accept fall in the same cycle, so err_count becomes 1.
REQ-026 SHALL preserve accepted words in order; no word may be dropped or duplicated.

Reset
REQ-027 SHALL, while rst_n=0, force the state to EMPTY, out_valid=0, in_ready=0, out_bin=0, out_step_err=0, err_count=0 and clear the "previous word valid" flag.
REQ-028 SHALL drive in_ready=1 on the first clock edge after rst_n is released.
REQ-029 SHALL discard buffered words when reset is asserted mid-stream, with no output transfer after reset.

Structure
REQ-030 SHALL take WIDTH and ERR_W defaults and the skid-state enum (EMPTY, ONE, TWO) from shared package gray_pkg.
REQ-031 SHALL put the combinational decode in one sub-module, gray_to_bin, instantiated once on the input path.

Verification
REQ-032 SHALL cover a streaming sweep: in_gray 0000,0001,0011,0010,...,1000 with out_ready=1 -> out_bin 0..15 in order, each 1 cycle after accept, out_step_err=0 throughout, err_count=0.
REQ-033 SHALL cover backpressure: out_ready=0 while sending 0001 then 0011 -> state TWO and in_ready=0; then out_ready=1 -> out_bin 1 then 2 in consecutive cycles, in_ready=1 one cycle later.
REQ-034 SHALL cover step errors: accept 0001, 0001, 0111 -> out_step_err pattern 0,1,1 and err_count=2; wrap 1000->0000 -> out_step_err=0.
REQ-035 SHALL cover saturation and clear: with ERR_W=2, 5 failing words -> err_count=3; clr_err together with a failing word -> err_count=1; clr_err alone -> 0.
REQ-036 SHALL cover reset mid-operation: rst_n=0 asynchronously while in TWO -> out_valid=0 immediately; the first word after release -> out_step_err=0.
